// File: rtl/la_iodebounce.sv
// la_iodebounce: pad input synchronizer with programmable debounce, edge pulses and sticky event flags
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   z                 asynchronous pad level
//   en                1 = debounce filter active, 0 = bypass (synchronized level)
//   dbcnt             threshold N; out changes after N+1 consecutive disagreeing cycles
//   clr               clears both sticky flags (a same-cycle event wins)
//   out               debounced level
//   rise, fall        one-cycle pulses on the first cycle of a new out value
//   rise_evt, fall_evt sticky event flags
module la_iodebounce #(
    parameter int STAGES = 2,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            z,
    input  logic            en,
    input  logic [CNTW-1:0] dbcnt,
    input  logic            clr,
    output logic            out,
    output logic            rise,
    output logic            fall,
    output logic            rise_evt,
    output logic            fall_evt
);
    logic [STAGES-1:0] sync_q;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              out_q, out_d, rise_q, fall_q, rise_evt_q, fall_evt_q;
    logic              s, hit, rise_d, fall_d;
    assign s = sync_q[STAGES-1];
    // >= rather than == so lowering dbcnt mid-count fires at once instead of stranding cnt
    always_comb begin
        hit    = en & (s != out_q) & (cnt_q >= dbcnt);
        out_d  = (!en || hit) ? s : out_q;
        cnt_d  = (!en || s == out_q || hit) ? '0 : cnt_q + 1'b1;
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            rise_evt_q <= 1'b0;
            fall_evt_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], z};
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rise_evt_q <= (rise_evt_q & ~clr) | rise_d;
            fall_evt_q <= (fall_evt_q & ~clr) | fall_d;
        end
    end
    assign out      = out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign rise_evt = rise_evt_q;
    assign fall_evt = fall_evt_q;
endmodule

// File: tb/tb_la_iodebounce.sv
// tb_la_iodebounce: directed scoreboard bench for la_iodebounce (STAGES=2, CNTW=16)
module tb_la_iodebounce;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        z = 1'b0;
    logic        en = 1'b0;
    logic [15:0] dbcnt = '0;
    logic        clr = 1'b0;
    logic        out, rise, fall, rise_evt, fall_evt;
    int          ncmp = 0;
    int          nerr = 0;

    typedef struct {
        bit         chk;
        logic [4:0] exp;
        string      name;
    } ent_t;
    ent_t sb[$];

    always #5 clk = ~clk;

    la_iodebounce #(.STAGES(2), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .z(z), .en(en), .dbcnt(dbcnt), .clr(clr),
        .out(out), .rise(rise), .fall(fall), .rise_evt(rise_evt), .fall_evt(fall_evt)
    );

    // one entry per edge; expected vector is {out, rise, fall, rise_evt, fall_evt}
    task automatic cyc(input int n, input bit r, input bit zz, input bit e,
                       input logic [15:0] d, input bit c, input logic [4:0] exp,
                       input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = r;
            z     = zz;
            en    = e;
            dbcnt = d;
            clr   = c;
            sb.push_back('{chk: (i == n - 1), exp: exp, name: nm});
        end
    endtask

    initial begin : monitor
        ent_t       ent;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            act = {out, rise, fall, rise_evt, fall_evt};
            ncmp++;
            if (rise && fall) begin
                nerr++;
                $display("FAIL rise_fall_excl: got rise=%b fall=%b want not both", rise, fall);
            end
            if (sb.size() > 0) begin
                ent = sb.pop_front();
                if (ent.chk) begin
                    ncmp++;
                    if (act !== ent.exp) begin
                        nerr++;
                        $display("FAIL %s: got %b want %b (out rise fall rise_evt fall_evt)",
                                 ent.name, act, ent.exp);
                    end
                end
            end
        end
    end

    initial begin
        cyc(3, 1, 1, 0, 0, 0, 5'b00000, "reset_hold");
        cyc(1, 0, 1, 0, 0, 0, 5'b00000, "byp_e1");
        cyc(1, 0, 1, 0, 0, 0, 5'b00000, "byp_e2");
        cyc(1, 0, 1, 0, 0, 0, 5'b11010, "byp_rise");
        cyc(1, 0, 1, 0, 0, 0, 5'b10010, "byp_rise_end");
        cyc(2, 0, 0, 0, 0, 0, 5'b10010, "byp_fall_wait");
        cyc(1, 0, 0, 0, 0, 0, 5'b00111, "byp_fall");
        cyc(1, 0, 0, 0, 0, 0, 5'b00011, "byp_fall_end");
        cyc(1, 0, 0, 0, 0, 1, 5'b00000, "clr_flags");
        cyc(1, 0, 0, 0, 0, 0, 5'b00000, "clr_hold");
        cyc(7, 0, 1, 1, 5, 0, 5'b00000, "db_wait");
        cyc(1, 0, 1, 1, 5, 0, 5'b11010, "db_rise");
        cyc(1, 0, 1, 1, 5, 0, 5'b10010, "db_rise_end");
        cyc(4, 0, 0, 1, 5, 0, 5'b10010, "glitch4");
        cyc(10, 0, 1, 1, 5, 0, 5'b10010, "glitch4_reject");
        cyc(5, 0, 0, 1, 5, 0, 5'b10010, "glitch5");
        cyc(10, 0, 1, 1, 5, 0, 5'b10010, "glitch5_reject");
        cyc(6, 0, 0, 1, 5, 0, 5'b10010, "pulse6");
        cyc(1, 0, 1, 1, 5, 0, 5'b10010, "pulse6_hold");
        cyc(1, 0, 1, 1, 5, 0, 5'b00111, "pulse6_fall");
        cyc(5, 0, 1, 1, 5, 0, 5'b00011, "pulse6_recount");
        cyc(1, 0, 1, 1, 5, 0, 5'b11011, "pulse6_rise");
        cyc(1, 0, 1, 1, 5, 0, 5'b10011, "pulse6_end");
        cyc(1, 0, 1, 1, 5, 1, 5'b10000, "clr_both");
        cyc(2, 0, 0, 0, 5, 0, 5'b10000, "coll_wait");
        cyc(1, 0, 0, 0, 5, 1, 5'b00101, "coll_set_wins");
        cyc(1, 0, 0, 0, 5, 1, 5'b00000, "coll_clr");
        cyc(2, 0, 1, 1, 0, 0, 5'b00000, "n0_wait");
        cyc(1, 0, 1, 1, 0, 0, 5'b11010, "n0_rise");
        cyc(1, 0, 1, 1, 0, 0, 5'b10010, "n0_end");
        cyc(42, 0, 0, 1, 100, 0, 5'b10010, "thr_count");
        cyc(1, 0, 0, 1, 10, 0, 5'b00111, "thr_lower");
        cyc(1, 0, 0, 1, 10, 0, 5'b00011, "thr_end");
        cyc(42, 0, 1, 1, 100, 0, 5'b00011, "endrop_count");
        cyc(1, 0, 1, 0, 100, 0, 5'b11011, "endrop_follow");
        cyc(1, 0, 1, 0, 100, 0, 5'b10011, "endrop_end");
        cyc(5, 0, 0, 1, 100, 0, 5'b10011, "pre_reset_count");
        cyc(1, 1, 0, 1, 100, 0, 5'b00000, "reset_mid");
        cyc(2, 1, 1, 1, 100, 0, 5'b00000, "reset_hold2");
        cyc(10, 0, 0, 1, 5, 0, 5'b00000, "post_reset_idle");
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            ncmp++;
            nerr++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
